sll_iter_32: RTL and testbench

- Multi-cycle logical left shifter for the processor's shift/ALU path; the left-direction counterpart to the combinational arithmetic right barrel shifter.
- Applies one power-of-two shift stage per clock (16, 8, 4, 2, 1), using a start/ready handshake like the multdiv unit.
- Flags any nonzero bit shifted out of the MSB end, so the core can detect left-shift overflow.

---
 rtl/sll_iter_32.sv | 101 ++++++++++
 tb/tb_sll_iter_32.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sll_iter_32.sv
// rtl/sll_iter_32.sv - multi-cycle logical left shifter, one power-of-two stage per clock
module sll_iter_32 #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [AMT_WIDTH-1:0]  shft_amt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_overflow,
  output logic                  data_resultRDY,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_WIDTH-1:0] LAST_STAGE = AMT_WIDTH[AMT_WIDTH-1:0] - 1'b1;
  localparam logic [AMT_WIDTH-1:0] TOP_STEP   = {1'b1, {(AMT_WIDTH-1){1'b0}}};

  state_t                state;
  logic [DATA_WIDTH-1:0] work;
  logic [AMT_WIDTH-1:0]  amt;
  logic                  ovf;
  logic [AMT_WIDTH-1:0]  stage;

  logic [AMT_WIDTH-1:0]  step;
  logic                  apply;
  logic [DATA_WIDTH-1:0] lost_mask;
  logic [DATA_WIDTH-1:0] stage_work;
  logic                  stage_ovf;

  // The amount register is consumed MSB-first, so the current stage's control
  // bit is always at the top and the step halves with each stage.
  always_comb begin
    step       = TOP_STEP >> stage;
    apply      = amt[AMT_WIDTH-1];
    lost_mask  = ~({DATA_WIDTH{1'b1}} >> step);
    stage_work = work;
    stage_ovf  = ovf;
    if (apply) begin
      stage_work = work << step;
      stage_ovf  = ovf | (|(work & lost_mask));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      work           <= '0;
      amt            <= '0;
      ovf            <= 1'b0;
      stage          <= '0;
      data_out       <= '0;
      data_overflow  <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ctrl_start) begin
            work  <= data_in;
            amt   <= shft_amt;
            ovf   <= 1'b0;
            stage <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // ctrl_start is deliberately ignored here; operands stay as latched.
          work <= stage_work;
          ovf  <= stage_ovf;
          amt  <= amt << 1;
          if (stage == LAST_STAGE) begin
            data_out       <= stage_work;
            data_overflow  <= stage_ovf;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end else begin
            stage <= stage + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sll_iter_32.sv
// tb/tb_sll_iter_32.sv - directed self-checking bench for sll_iter_32
module tb_sll_iter_32;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_in;
  logic [4:0]  shft_amt;
  logic [31:0] data_out;
  logic        data_overflow;
  logic        data_resultRDY;
  logic        busy;

  int pass_cnt;
  int total_cnt;

  sll_iter_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .data_in        (data_in),
    .shft_amt       (shft_amt),
    .data_out       (data_out),
    .data_overflow  (data_overflow),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at a negedge; the start is sampled at the following posedge.
  task automatic issue_now(input logic [31:0] d, input logic [4:0] a);
    ctrl_start = 1'b1;
    data_in    = d;
    shft_amt   = a;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
  endtask

  // Sample at each negedge until RDY; lat is -1 if it never arrives.
  task automatic wait_rdy(input logic [31:0] hold, output int lat, output int busy_n,
                          output int hold_bad);
    lat      = -1;
    busy_n   = 0;
    hold_bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        lat = n;
        break;
      end
      if (busy === 1'b1) busy_n++;
      if (data_out !== hold) hold_bad++;
      @(posedge clock);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    ctrl_start = 1'b0;
    data_in    = '0;
    shft_amt   = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total_cnt++;
    if (data_out !== 32'h0) $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (data_overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", data_overflow);
    else pass_cnt++;
    total_cnt++;
    if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy: got %b expected 0", data_resultRDY);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_max_shift;
    int lat, bn, hb;
    @(negedge clock);
    issue_now(32'h00000001, 5'd31);
    wait_rdy(32'h0, lat, bn, hb);
    total_cnt++;
    if (lat !== 5) $display("FAIL max_latency: got %0d expected 5", lat);
    else pass_cnt++;
    total_cnt++;
    if (bn !== 5) $display("FAIL max_busy_cycles: got %0d expected 5", bn);
    else pass_cnt++;
    total_cnt++;
    if (hb !== 0) $display("FAIL max_hold_before_rdy: got %0d expected 0", hb);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'h80000000) $display("FAIL max_data: got %h expected %h", data_out, 32'h80000000);
    else pass_cnt++;
    total_cnt++;
    if (data_overflow !== 1'b0) $display("FAIL max_overflow: got %b expected 0", data_overflow);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (data_resultRDY !== 1'b0) $display("FAIL max_rdy_width: got %b expected 0", data_resultRDY);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    int lat, bn, hb;
    @(negedge clock);
    issue_now(32'hF0000001, 5'd4);
    wait_rdy(32'h80000000, lat, bn, hb);
    total_cnt++;
    if (data_out !== 32'h00000010) $display("FAIL ovf_data: got %h expected %h", data_out, 32'h00000010);
    else pass_cnt++;
    total_cnt++;
    if (data_overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", data_overflow);
    else pass_cnt++;
    @(negedge clock);
    issue_now(32'h0FFFFFFF, 5'd4);
    wait_rdy(32'h00000010, lat, bn, hb);
    total_cnt++;
    if (data_out !== 32'hFFFFFFF0) $display("FAIL noovf_data: got %h expected %h", data_out, 32'hFFFFFFF0);
    else pass_cnt++;
    total_cnt++;
    if (data_overflow !== 1'b0) $display("FAIL noovf_flag: got %b expected 0", data_overflow);
    else pass_cnt++;
    total_cnt++;
    if (hb !== 0) $display("FAIL noovf_hold: got %0d expected 0", hb);
    else pass_cnt++;
  endtask

  task automatic test_zero_shift;
    int lat, bn, hb;
    @(negedge clock);
    issue_now(32'hDEADBEEF, 5'd0);
    wait_rdy(32'hFFFFFFF0, lat, bn, hb);
    total_cnt++;
    if (lat !== 5) $display("FAIL zero_latency: got %0d expected 5", lat);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'hDEADBEEF) $display("FAIL zero_data: got %h expected %h", data_out, 32'hDEADBEEF);
    else pass_cnt++;
    total_cnt++;
    if (data_overflow !== 1'b0) $display("FAIL zero_overflow: got %b expected 0", data_overflow);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy;
    int rdy_n;
    rdy_n = 0;
    @(negedge clock);
    issue_now(32'h00000001, 5'd1);
    @(posedge clock);
    @(negedge clock);
    issue_now(32'h00000002, 5'd3);
    for (int n = 0; n < 14; n++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_n++;
    end
    total_cnt++;
    if (rdy_n !== 1) $display("FAIL busy_rdy_count: got %0d expected 1", rdy_n);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'h00000002) $display("FAIL busy_data: got %h expected %h", data_out, 32'h00000002);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_idle_after: got %b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op;
    int rdy_n, lat, bn, hb;
    rdy_n = 0;
    @(negedge clock);
    issue_now(32'h12345678, 5'd8);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (data_out !== 32'h0) $display("FAIL rstmid_data: got %h expected %h", data_out, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (data_resultRDY !== 1'b0) $display("FAIL rstmid_rdy: got %b expected 0", data_resultRDY);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_n++;
    end
    total_cnt++;
    if (rdy_n !== 0) $display("FAIL rstmid_no_rdy: got %0d expected 0", rdy_n);
    else pass_cnt++;
    issue_now(32'h00000003, 5'd2);
    wait_rdy(32'h0, lat, bn, hb);
    total_cnt++;
    if (data_out !== 32'h0000000C) $display("FAIL rstmid_followup: got %h expected %h", data_out, 32'h0000000C);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bn, hb;
    @(negedge clock);
    issue_now(32'h00000001, 5'd1);
    wait_rdy(32'h0000000C, lat, bn, hb);
    total_cnt++;
    if (data_out !== 32'h00000002) $display("FAIL b2b_first: got %h expected %h", data_out, 32'h00000002);
    else pass_cnt++;
    issue_now(32'h00000001, 5'd2);
    wait_rdy(32'h00000002, lat, bn, hb);
    total_cnt++;
    if (lat !== 5) $display("FAIL b2b_latency: got %0d expected 5", lat);
    else pass_cnt++;
    total_cnt++;
    if (bn !== 5) $display("FAIL b2b_busy_cycles: got %0d expected 5", bn);
    else pass_cnt++;
    total_cnt++;
    if (hb !== 0) $display("FAIL b2b_hold: got %0d expected 0", hb);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'h00000004) $display("FAIL b2b_second: got %h expected %h", data_out, 32'h00000004);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_max_shift();
    test_overflow();
    test_zero_shift();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
